alu_muldiv_ctrl: RTL and testbench

- Parametrised ALU control for the single-cycle core.
- Decodes aluOp/funct into an extended 4-bit aluControl code.
- Owns an iterative multi-cycle multiply/divide engine with HI/LO registers, so the datapath gains MULT/MULTU/DIV/DIVU/MFHI/MFLO.
- Produces a stall to freeze the PC and a result select for the writeback mux.

---
 rtl/alu_muldiv_ctrl_if.sv | 28 ++
 rtl/alu_muldiv_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_ctrl_if.sv
// Execute-stage bundle between the datapath and the ALU / mul-div control.
// The datapath drives the master side; the control block is the slave.
interface alu_muldiv_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             en;
   logic [1:0]       aluOp;
   logic [5:0]       funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       aluControl;
   logic [1:0]       result_sel;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output en, aluOp, funct, a, b,
      input  aluControl, result_sel, stall, busy, done, hi, lo
   );

   modport slave (
      input  en, aluOp, funct, a, b,
      output aluControl, result_sel, stall, busy, done, hi, lo
   );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// ALU control decode plus an iterative multiply/divide engine owning HI/LO.
// Shift-add multiply and restoring divide on magnitudes, sign fixed at the end.
module alu_muldiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic               clk,
   input logic               reset,
   alu_muldiv_ctrl_if.slave  bus
);
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;
   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               div_q, div_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   araw_q, araw_d;
   logic [WIDTH-1:0]   mc_q, mc_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic [3:0]         alu_ctl;
   logic [1:0]         rsel;
   logic               is_md;
   logic               md_req;
   logic               mf_req;
   logic               busy;

   always_comb begin
      alu_ctl = 4'b0010;
      unique case (bus.aluOp)
         2'b00: alu_ctl = 4'b0010;
         2'b01: alu_ctl = 4'b0110;
         2'b11: alu_ctl = 4'b1111;
         default: begin
            case (bus.funct)
               F_ADD:   alu_ctl = 4'b0010;
               F_SUB:   alu_ctl = 4'b0110;
               F_AND:   alu_ctl = 4'b0000;
               F_OR:    alu_ctl = 4'b0001;
               F_XOR:   alu_ctl = 4'b1101;
               F_NOR:   alu_ctl = 4'b1100;
               F_SLT:   alu_ctl = 4'b0111;
               F_SLTU:  alu_ctl = 4'b1111;
               F_SLL:   alu_ctl = 4'b1000;
               F_SRL:   alu_ctl = 4'b1001;
               F_SRA:   alu_ctl = 4'b1010;
               default: alu_ctl = 4'b0010;
            endcase
         end
      endcase
   end

   always_comb begin
      rsel = 2'b00;
      if (bus.aluOp == 2'b10) begin
         if (bus.funct == F_MFHI) rsel = 2'b01;
         if (bus.funct == F_MFLO) rsel = 2'b10;
      end
   end

   assign is_md  = (bus.aluOp == 2'b10) && (bus.funct[5:2] == 4'b0110);
   assign md_req = bus.en && is_md;
   assign mf_req = bus.en && (rsel != 2'b00);
   assign busy   = (state_q != S_IDLE);

   assign bus.aluControl = alu_ctl;
   assign bus.result_sel = rsel;
   assign bus.stall      = busy && (md_req || mf_req);
   assign bus.busy       = busy;
   assign bus.done       = done_q;
   assign bus.hi         = hi_q;
   assign bus.lo         = lo_q;

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? mc_q : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff = rem_sh - {1'b0, mc_q};
   assign div_next = div_diff[WIDTH]
                   ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   logic               sgn;
   logic               sa;
   logic               sb;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      araw_d   = araw_q;
      mc_d     = mc_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      sgn      = ~bus.funct[0];
      sa       = sgn & bus.a[WIDTH-1];
      sb       = sgn & bus.b[WIDTH-1];
      prod_fix = neg_q ? -acc_q : acc_q;
      quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                        : acc_q[2*WIDTH-1:WIDTH];
      unique case (state_q)
         S_IDLE: begin
            if (md_req) begin
               state_d = S_RUN;
               cnt_d   = '0;
               div_d   = bus.funct[1];
               neg_d   = sa ^ sb;
               rneg_d  = sa;
               dz_d    = bus.funct[1] && (bus.b == '0);
               araw_d  = bus.a;
               mc_d    = sb ? -bus.b : bus.b;
               acc_d   = {{WIDTH{1'b0}}, (sa ? -bus.a : bus.a)};
            end
         end
         S_RUN: begin
            acc_d = div_q ? div_next : mul_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (!div_q) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else if (dz_q) begin
               hi_d = araw_q;
               lo_d = {WIDTH{1'b1}};
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         araw_q  <= '0;
         mc_q    <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         araw_q  <= araw_d;
         mc_q    <= mc_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed bench for alu_muldiv_ctrl: decode table, mul/div results,
// latency, stall behaviour, back-to-back issue and mid-operation reset.
module tb_alu_muldiv_ctrl;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   logic clk;
   logic reset;
   int   checks;
   int   fails;

   alu_muldiv_ctrl_if #(.WIDTH(32)) bus ();

   alu_muldiv_ctrl #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called just after the accept edge (cycle 1); returns at done cycle.
   task automatic wait_done(output int nb, output int ns, output int dc);
      nb = 0;
      ns = 0;
      dc = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (bus.busy) nb++;
         if (bus.stall) ns++;
         if (bus.done) begin
            dc = c;
            break;
         end
      end
   endtask

   task automatic issue(logic [5:0] f, logic [31:0] av, logic [31:0] bv);
      @(negedge clk);
      bus.en    = 1'b1;
      bus.aluOp = 2'b10;
      bus.funct = f;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(string tag, logic [5:0] f, logic [31:0] av,
                         logic [31:0] bv, logic [31:0] eh,
                         logic [31:0] el);
      int nb, ns, dc;
      issue(f, av, bv);
      bus.en    = 1'b0;
      bus.funct = 6'b100000;
      wait_done(nb, ns, dc);
      check({tag, "_busy_cycles"}, 64'(nb), 64'd33);
      check({tag, "_done_cycle"}, 64'(dc), 64'd34);
      check({tag, "_hi"}, 64'(bus.hi), 64'(eh));
      check({tag, "_lo"}, 64'(bus.lo), 64'(el));
   endtask

   logic [5:0] fv [11];
   logic [3:0] cv [11];

   initial begin
      int nb, ns, dc, np;
      checks    = 0;
      fails     = 0;
      reset     = 1'b1;
      bus.en    = 1'b0;
      bus.aluOp = 2'b00;
      bus.funct = 6'b0;
      bus.a     = '0;
      bus.b     = '0;
      fv = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
             6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
             6'b000011};
      cv = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1101, 4'b1100,
             4'b0111, 4'b1111, 4'b1000, 4'b1001, 4'b1010};
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);

      bus.aluOp = 2'b10;
      for (int i = 0; i < 11; i++) begin
         bus.funct = fv[i];
         #1;
         check($sformatf("dec_f%02h", fv[i]), 64'(bus.aluControl),
               64'(cv[i]));
         check($sformatf("rsel_f%02h", fv[i]), 64'(bus.result_sel),
               64'd0);
      end
      bus.funct = 6'b111111;
      #1 check("dec_other", 64'(bus.aluControl), 64'b0010);
      bus.funct = F_MFHI;
      #1 check("rsel_mfhi", 64'(bus.result_sel), 64'b01);
      bus.funct = F_MFLO;
      #1 check("rsel_mflo", 64'(bus.result_sel), 64'b10);
      bus.aluOp = 2'b00;
      #1 check("dec_op00", 64'(bus.aluControl), 64'b0010);
      check("rsel_op00", 64'(bus.result_sel), 64'b00);
      bus.aluOp = 2'b01;
      #1 check("dec_op01", 64'(bus.aluControl), 64'b0110);
      bus.aluOp = 2'b11;
      #1 check("dec_op11", 64'(bus.aluControl), 64'b1111);

      run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFE, 32'h00000001);
      run_op("mult_neg", F_MULT, 32'hFFFFFFFD, 32'd7,
             32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2,
             32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu_zero", F_DIVU, 32'd100, 32'd0,
             32'd100, 32'hFFFFFFFF);
      run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF,
             32'd0, 32'h80000000);
      run_op("div_zero", F_DIV, 32'hFFFFFFF0, 32'd0,
             32'hFFFFFFF0, 32'hFFFFFFFF);

      issue(F_MULTU, 32'd6, 32'd7);
      bus.funct = F_MFLO;
      wait_done(nb, ns, dc);
      check("mflo_stall_cycles", 64'(ns), 64'd33);
      check("mflo_done_cycle", 64'(dc), 64'd34);
      check("mflo_stall_off", 64'(bus.stall), 64'd0);
      check("mflo_rsel", 64'(bus.result_sel), 64'b10);
      check("mflo_lo", 64'(bus.lo), 64'd42);
      bus.en = 1'b0;

      issue(F_MULTU, 32'd6, 32'd7);
      bus.a = 32'd3;
      bus.b = 32'd5;
      wait_done(nb, ns, dc);
      check("b2b_stall_cycles", 64'(ns), 64'd33);
      check("b2b_first_done", 64'(dc), 64'd34);
      check("b2b_first_lo", 64'(bus.lo), 64'd42);
      check("b2b_no_stall", 64'(bus.stall), 64'd0);
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      wait_done(nb, ns, dc);
      check("b2b_second_done", 64'(dc), 64'd34);
      check("b2b_second_busy", 64'(nb), 64'd33);
      check("b2b_second_lo", 64'(bus.lo), 64'd15);
      check("b2b_second_hi", 64'(bus.hi), 64'd0);

      issue(F_DIVU, 32'd1000, 32'd7);
      bus.en = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", 64'(bus.busy), 64'd0);
      check("mid_rst_hi", 64'(bus.hi), 64'd0);
      check("mid_rst_lo", 64'(bus.lo), 64'd0);
      check("mid_rst_done", 64'(bus.done), 64'd0);
      np = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) np++;
      end
      check("mid_rst_no_done", 64'(np), 64'd0);
      run_op("divu_after_rst", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
